otp_stream_xor: RTL and testbench
=================================

// Module: otp_stream_xor
// PURPOSE
//  Parametrised successor to the single-byte static-key XOR stage: loads a KEY_WORDS-deep key pad after
//  reset, then XORs a valid/ready data stream with successive pad words. Optional one-time mode retires
//  the pad after a single pass. Sits between plaintext source and ciphertext sink in the side-channel test harness.
// PARAMETERS
//  WIDTH     8  data/key word width in bits (>=1)
//  KEY_WORDS 4  pad depth in words (>=1); IDXW = max(1,$clog2(KEY_WORDS))
//  ONE_TIME  1  1: pad usable once, then SPENT; 0: pad index wraps and is reused
// PORTS
//  clk        in  1        single clock, rising edge
//  reset      in  1        synchronous, active-low reset
//  key_valid  in  1        key word offered
//  key_data   in  WIDTH    key word
//  key_ready  out 1        key word accepted when key_valid & key_ready
//  in_valid   in  1        plaintext word offered
//  in_data    in  WIDTH    plaintext word
//  in_ready   out 1        plaintext accepted when in_valid & in_ready
//  out_valid  out 1        ciphertext word held
//  out_data   out WIDTH    ciphertext = plaintext ^ pad word
//  out_ready  in  1        sink accepts when out_valid & out_ready
//  key_loaded out 1        pad complete (state RUN or SPENT)
//  pad_spent  out 1        one-time pad exhausted (state SPENT)
//  key_idx    out IDXW     pad index of next plaintext word
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state=LOAD, wr_ptr=0, key_idx=0, out_valid=0, out_data=0,
//    key_loaded=0, pad_spent=0. Reset dominates all handshakes; a held output word is discarded.
//  - FSM LOAD -> RUN -> SPENT (SPENT only when ONE_TIME=1); leaving SPENT or reloading the pad needs reset.
//  - LOAD: key_ready=1, in_ready=0. Each key beat writes key_mem[wr_ptr], wr_ptr++. The beat with
//    wr_ptr==KEY_WORDS-1 moves to RUN next cycle; key_loaded=1 from that cycle.
//  - RUN/SPENT: key_ready=0; key_valid ignored, key_mem unchanged.
//  - in_ready = (state==RUN) & (~out_valid | out_ready), combinational; no dependence on in_valid.
//  - Input beat: out_data <= in_data ^ key_mem[key_idx]; out_valid <= 1; latency 1 cycle.
//    key_idx increments; from KEY_WORDS-1 it wraps to 0.
//  - Beat on key_idx==KEY_WORDS-1 with ONE_TIME=1 -> SPENT next cycle; pad_spent=1, in_ready=0.
//    The word already held still drains normally.
//  - Output: out_valid & ~out_ready holds out_data stable. out_ready & no input beat clears out_valid.
//  - Simultaneous output drain and input beat gives sustained 1 word/cycle.
//  - out_data keeps its last value after drain; consumers use it only while out_valid=1.
//  - KEY_WORDS=1: key_idx is constant 0. ONE_TIME=1 spends the pad after one word.
// CONFIGURATION
//  KEY_ZEROIZE_EN defined: reset also clears every key_mem word to 0 in the same edge, and on
//    entry to SPENT every key_mem word is cleared to 0 in the same edge.
//  Not defined: key_mem has no reset and keeps contents across reset and SPENT (legacy leak-study
//    behaviour). Readback is possible only through out_data.
// TESTING
//  T1 WIDTH=8,KEY_WORDS=4: load A5,3C,0F,FF; send 00,11,22,33 -> A5,2D,2D,CC; pad_spent=1; in_ready=0.
//  T2 ONE_TIME=0: same pad, send 8 words of 00 -> A5,3C,0F,FF,A5,3C,0F,FF; key_idx wraps 3->0; pad_spent=0.
//  T3 out_ready=0 for 3 cycles after first beat -> out_data=A5 held, in_ready=0; release -> 1 word/cycle.
//  T4 key_valid during RUN with key_data=00 -> key_ready=0, next ciphertext still uses old pad.
//  T5 reset low mid-stream with out_valid=1 -> next cycle out_valid=0, key_loaded=0, key_idx=0, key_ready=1.
//  T6 KEY_ZEROIZE_EN: reset after load, then reload and send 00 -> uses new key.
//     Also probe key_mem after reset: reads 0 with macro defined, old key without it.

Source files
------------

// File: rtl/otp_stream_xor.sv
// Streaming XOR stage: loads a KEY_WORDS-deep pad after reset, then XORs a valid/ready stream with it.
// Define KEY_ZEROIZE_EN to clear the pad on reset and on entry to SPENT.
module otp_stream_xor #(
   parameter int  WIDTH     = 8,
   parameter int  KEY_WORDS = 4,
   parameter bit  ONE_TIME  = 1'b1,
   localparam int IDXW      = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_valid,
   input  logic [WIDTH-1:0] key_data,
   output logic             key_ready,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             key_loaded,
   output logic             pad_spent,
   output logic [IDXW-1:0]  key_idx
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_RUN   = 2'd1,
      S_SPENT = 2'd2
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(KEY_WORDS - 1);

   state_t           state_q, state_d;
   logic [IDXW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDXW-1:0]  key_idx_q, key_idx_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] key_mem_q [KEY_WORDS];

   logic key_beat;
   logic in_beat;

   assign key_ready = (state_q == S_LOAD);
   assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
   assign key_beat  = key_valid && key_ready;
   assign in_beat   = in_valid && in_ready;

   // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      key_idx_d   = key_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (key_beat) begin
         wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
         if (wr_ptr_q == LAST_IDX) begin
            state_d = S_RUN;
         end
      end

      if (in_beat) begin
         out_data_d  = in_data ^ key_mem_q[key_idx_q];
         out_valid_d = 1'b1;
         key_idx_d   = (key_idx_q == LAST_IDX) ? '0 : key_idx_q + 1'b1;
         if (ONE_TIME && (key_idx_q == LAST_IDX)) begin
            state_d = S_SPENT;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_LOAD;
         wr_ptr_q    <= '0;
         key_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         key_idx_q   <= key_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef KEY_ZEROIZE_EN
   logic spend_now;
   assign spend_now = ONE_TIME && in_beat && (key_idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!reset || spend_now) begin
         for (int i = 0; i < KEY_WORDS; i++) begin
            key_mem_q[i] <= '0;
         end
      end else if (key_beat) begin
         key_mem_q[wr_ptr_q] <= key_data;
      end
   end
`else
   // NOTE: the pad is deliberately left out of reset; it keeps its contents across reset and SPENT.
   always_ff @(posedge clk) begin
      if (key_beat) begin
         key_mem_q[wr_ptr_q] <= key_data;
      end
   end
`endif

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign key_loaded = (state_q == S_RUN) || (state_q == S_SPENT);
   assign pad_spent  = (state_q == S_SPENT);
   assign key_idx    = key_idx_q;

endmodule

// File: tb/tb_otp_stream_xor.sv
// Bench for otp_stream_xor: one-time instance (u_ot) and reusable-pad instance (u_rp),
// checked every cycle against a count-based model plus directed literal expectations.
module tb_otp_stream_xor;

   logic       clk;
   logic       reset     [2];
   logic       key_valid [2];
   logic [7:0] key_data  [2];
   logic       key_ready [2];
   logic       in_valid  [2];
   logic [7:0] in_data   [2];
   logic       in_ready  [2];
   logic       out_valid [2];
   logic [7:0] out_data  [2];
   logic       out_ready [2];
   logic       key_loaded[2];
   logic       pad_spent [2];
   logic [1:0] key_idx   [2];

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state per channel
   bit         m_known [2];
   int         m_keys  [2];
   int         m_words [2];
   logic [7:0] m_pad   [2][4];
   bit         m_held  [2];
   logic [7:0] m_data  [2];
   logic [7:0] cap0[$];
   logic [7:0] cap1[$];

   otp_stream_xor #(.WIDTH(8), .KEY_WORDS(4), .ONE_TIME(1'b1)) u_ot (
      .clk(clk), .reset(reset[0]),
      .key_valid(key_valid[0]), .key_data(key_data[0]), .key_ready(key_ready[0]),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
      .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
      .key_loaded(key_loaded[0]), .pad_spent(pad_spent[0]), .key_idx(key_idx[0])
   );

   otp_stream_xor #(.WIDTH(8), .KEY_WORDS(4), .ONE_TIME(1'b0)) u_rp (
      .clk(clk), .reset(reset[1]),
      .key_valid(key_valid[1]), .key_data(key_data[1]), .key_ready(key_ready[1]),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
      .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
      .key_loaded(key_loaded[1]), .pad_spent(pad_spent[1]), .key_idx(key_idx[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: pad loaded once 4 keys accepted; one-time pad spent once 4 words accepted;
   // pad index is the accepted-word count modulo 4.
   initial begin : compare
      bit ld, sp, ir, kb, ib, ob, one_time;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            one_time = (c == 0);
            ld = (m_keys[c] >= 4);
            sp = one_time && (m_words[c] >= 4);
            ir = ld && !sp && (!m_held[c] || out_ready[c]);
            if (m_known[c]) begin
               check($sformatf("ch%0d key_ready", c), 32'(key_ready[c]), 32'(!ld));
               check($sformatf("ch%0d key_loaded", c), 32'(key_loaded[c]), 32'(ld));
               check($sformatf("ch%0d pad_spent", c), 32'(pad_spent[c]), 32'(sp));
               check($sformatf("ch%0d in_ready", c), 32'(in_ready[c]), 32'(ir));
               check($sformatf("ch%0d out_valid", c), 32'(out_valid[c]), 32'(m_held[c]));
               check($sformatf("ch%0d out_data", c), 32'(out_data[c]), 32'(m_data[c]));
               check($sformatf("ch%0d key_idx", c), 32'(key_idx[c]), 32'(m_words[c] % 4));
            end
            if (reset[c] && out_valid[c] && out_ready[c]) begin
               if (c == 0) cap0.push_back(out_data[c]);
               else        cap1.push_back(out_data[c]);
            end
            if (!reset[c]) begin
               m_known[c] = 1'b1;
               m_keys[c]  = 0;
               m_words[c] = 0;
               m_held[c]  = 1'b0;
               m_data[c]  = 8'h00;
`ifdef KEY_ZEROIZE_EN
               for (int i = 0; i < 4; i++) m_pad[c][i] = 8'h00;
`endif
            end else begin
               kb = !ld && key_valid[c];
               ib = ir && in_valid[c];
               ob = m_held[c] && out_ready[c];
               if (kb) begin
                  m_pad[c][m_keys[c]] = key_data[c];
                  m_keys[c]++;
               end
               if (ib) begin
                  m_data[c] = in_data[c] ^ m_pad[c][m_words[c] % 4];
                  m_held[c] = 1'b1;
                  m_words[c]++;
`ifdef KEY_ZEROIZE_EN
                  if (one_time && m_words[c] == 4)
                     for (int i = 0; i < 4; i++) m_pad[c][i] = 8'h00;
`endif
               end else if (ob) begin
                  m_held[c] = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input int c, input logic [7:0] k0, input logic [7:0] k1,
                           input logic [7:0] k2, input logic [7:0] k3);
      logic [7:0] k [4];
      k = '{k0, k1, k2, k3};
      for (int i = 0; i < 4; i++) begin
         key_valid[c] = 1'b1;
         key_data[c]  = k[i];
         tick();
      end
      key_valid[c] = 1'b0;
   endtask

   task automatic send(input int c, input logic [7:0] d);
      in_valid[c] = 1'b1;
      in_data[c]  = d;
      for (int i = 0; i < 20; i++) begin
         if (in_ready[c]) begin
            tick();
            in_valid[c] = 1'b0;
            return;
         end
         tick();
      end
      in_valid[c] = 1'b0;
      check($sformatf("ch%0d send timeout", c), 32'd0, 32'd1);
   endtask

   task automatic expect_cap(input int c, input string name, input logic [7:0] exp[$]);
      logic [7:0] got[$];
      got = (c == 0) ? cap0 : cap1;
      check({name, " count"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s word%0d", name, i), 32'(got[i]), 32'(exp[i]));
   endtask

   initial begin
      logic [7:0] exp_q[$];
      logic [7:0] old_pad[4];
      for (int c = 0; c < 2; c++) begin
         reset[c] = 1'b0; key_valid[c] = 1'b0; key_data[c] = 8'h00;
         in_valid[c] = 1'b0; in_data[c] = 8'h00; out_ready[c] = 1'b1;
      end
      tick(); tick();
      reset[0] = 1'b1; reset[1] = 1'b1;
      tick();
      check("reset key_ready", 32'(key_ready[0]), 32'd1);
      check("reset out_valid", 32'(out_valid[0]), 32'd0);
      check("reset out_data", 32'(out_data[0]), 32'd0);

      // T1: one-time pad
      load_key(0, 8'hA5, 8'h3C, 8'h0F, 8'hFF);
      check("T1 key_loaded", 32'(key_loaded[0]), 32'd1);
      send(0, 8'h00); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
      tick(); tick();
      exp_q = '{8'hA5, 8'h2D, 8'h2D, 8'hCC};
      expect_cap(0, "T1 cipher", exp_q);
      check("T1 pad_spent", 32'(pad_spent[0]), 32'd1);
      check("T1 in_ready", 32'(in_ready[0]), 32'd0);
      in_valid[0] = 1'b1; in_data[0] = 8'h55;
      tick(); tick(); tick();
      in_valid[0] = 1'b0;
      check("T1 no beat after spent", 32'(cap0.size()), 32'd4);

      // T2: reusable pad wraps
      load_key(1, 8'hA5, 8'h3C, 8'h0F, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         send(1, 8'h00);
         if (i == 2) check("T2 key_idx 3", 32'(key_idx[1]), 32'd3);
         if (i == 3) check("T2 key_idx wrap", 32'(key_idx[1]), 32'd0);
      end
      tick();
      exp_q = '{8'hA5, 8'h3C, 8'h0F, 8'hFF, 8'hA5, 8'h3C, 8'h0F, 8'hFF};
      expect_cap(1, "T2 cipher", exp_q);
      check("T2 pad_spent", 32'(pad_spent[1]), 32'd0);

      // T3: backpressure then sustained throughput
      cap1.delete();
      out_ready[1] = 1'b0;
      in_valid[1] = 1'b1; in_data[1] = 8'h00;
      tick();
      in_data[1] = 8'h11;
      for (int i = 0; i < 3; i++) begin
         check("T3 held valid", 32'(out_valid[1]), 32'd1);
         check("T3 held data", 32'(out_data[1]), 32'hA5);
         check("T3 in_ready low", 32'(in_ready[1]), 32'd0);
         tick();
      end
      out_ready[1] = 1'b1;
      tick();
      check("T3 stream data1", 32'(out_data[1]), 32'h2D);
      in_data[1] = 8'h22;
      tick();
      check("T3 stream data2", 32'(out_data[1]), 32'h2D);
      in_data[1] = 8'h33;
      tick();
      check("T3 stream data3", 32'(out_data[1]), 32'hCC);
      in_valid[1] = 1'b0;
      tick();
      exp_q = '{8'hA5, 8'h2D, 8'h2D, 8'hCC};
      expect_cap(1, "T3 cipher", exp_q);

      // T4: key beats ignored while running
      cap1.delete();
      key_valid[1] = 1'b1; key_data[1] = 8'h00;
      check("T4 key_ready", 32'(key_ready[1]), 32'd0);
      tick(); tick();
      key_valid[1] = 1'b0;
      send(1, 8'h00);
      tick();
      exp_q = '{8'hA5};
      expect_cap(1, "T4 cipher", exp_q);

      // T5: reset mid-stream with a held word
      out_ready[1] = 1'b0;
      send(1, 8'h00);
      check("T5 held before reset", 32'(out_valid[1]), 32'd1);
      check("T5 held data", 32'(out_data[1]), 32'h3C);
      reset[1] = 1'b0;
      tick();
      reset[1] = 1'b1;
      check("T5 out_valid", 32'(out_valid[1]), 32'd0);
      check("T5 key_loaded", 32'(key_loaded[1]), 32'd0);
      check("T5 key_idx", 32'(key_idx[1]), 32'd0);
      check("T5 key_ready", 32'(key_ready[1]), 32'd1);
      out_ready[1] = 1'b1;

      // T6: pad contents after reset, then reload
      old_pad = '{8'hA5, 8'h3C, 8'h0F, 8'hFF};
      for (int i = 0; i < 4; i++) begin
`ifdef KEY_ZEROIZE_EN
         check($sformatf("T6 rp pad%0d", i), 32'(u_rp.key_mem_q[i]), 32'd0);
`else
         check($sformatf("T6 rp pad%0d", i), 32'(u_rp.key_mem_q[i]), 32'(old_pad[i]));
`endif
      end
      cap1.delete();
      load_key(1, 8'h11, 8'h22, 8'h33, 8'h44);
      send(1, 8'h00);
      send(1, 8'hF0);
      tick();
      exp_q = '{8'h11, 8'hD2};
      expect_cap(1, "T6 new key", exp_q);

      reset[0] = 1'b0;
      tick();
      reset[0] = 1'b1;
      check("T6 ot key_ready", 32'(key_ready[0]), 32'd1);
      for (int i = 0; i < 4; i++) begin
`ifdef KEY_ZEROIZE_EN
         check($sformatf("T6 ot pad%0d", i), 32'(u_ot.key_mem_q[i]), 32'd0);
`else
         check($sformatf("T6 ot pad%0d", i), 32'(u_ot.key_mem_q[i]), 32'(old_pad[i]));
`endif
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
